// File: rtl/maq_controle.sv
// maq_controle -- mode/sequencing controller for the digital clock counter chain.
//
// Produces the 1 Hz count tick while running and runs the time-set interface:
// the mode button cycles RUN -> SET_HORA -> SET_MIN -> RUN, and the increment
// button issues single-cycle adjust pulses to the hour/minute machines.
// A set mode left idle for TIMEOUT_S seconds falls back to RUN on its own.
//
// Ports:
//   maqc_clock        in   system clock, rising edge
//   maqc_reset        in   asynchronous active-low reset
//   maqc_btn_modo     in   raw mode button (async, active-high)
//   maqc_btn_inc      in   raw increment button (async, active-high)
//   maqc_enable       out  1 in RUN: count enable for the seconds chain
//   maqc_tick_seg     out  one-cycle 1 Hz pulse, RUN only
//   maqc_ajuste_hora  out  one-cycle hour adjust pulse
//   maqc_ajuste_min   out  one-cycle minute adjust pulse
//   maqc_zera_seg     out  one-cycle pulse clearing seconds on exit from a set mode
//   maqc_modo         out  00 RUN, 01 SET_HORA, 10 SET_MIN
//   maqc_pisca        out  display blink: 1 shows the field being set, 0 blanks it
module maq_controle #(
    parameter int unsigned DIV       = 50000000,
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       maqc_clock,
    input  logic       maqc_reset,
    input  logic       maqc_btn_modo,
    input  logic       maqc_btn_inc,
    output logic       maqc_enable,
    output logic       maqc_tick_seg,
    output logic       maqc_ajuste_hora,
    output logic       maqc_ajuste_min,
    output logic       maqc_zera_seg,
    output logic [1:0] maqc_modo,
    output logic       maqc_pisca
);

    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(DIV / 2);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HORA = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] to_q, to_d;

    // bit 0 = modo, bit 1 = inc
    logic [1:0] btn_s1_q, btn_s2_q, btn_prev_q;
    logic [1:0] btn_edge;
    logic       modo_edge, inc_edge, tick;

    logic enable_q, enable_d;
    logic tick_q, tick_d;
    logic ajh_q, ajh_d;
    logic ajm_q, ajm_d;
    logic zera_q, zera_d;
    logic pisca_q, pisca_d;
    logic exit_set;

    assign btn_edge  = btn_s2_q & ~btn_prev_q;
    assign modo_edge = btn_edge[0];
    assign inc_edge  = btn_edge[1];
    assign tick      = (presc_q == PRESC_LAST);

    always_comb begin
        state_d  = state_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        to_d     = to_q;
        tick_d   = 1'b0;
        ajh_d    = 1'b0;
        ajm_d    = 1'b0;
        zera_d   = 1'b0;
        exit_set = 1'b0;

        unique case (state_q)
            RUN: begin
                tick_d = tick;
                if (modo_edge) begin
                    state_d = SET_HORA;
                    to_d    = '0;
                end
            end
            SET_HORA, SET_MIN: begin
                // Priority: modo edge, then inc edge, then timeout expiry.
                // Any button edge restarts the idle timeout.
                if (modo_edge) begin
                    to_d = '0;
                    if (state_q == SET_HORA) state_d = SET_MIN;
                    else                     exit_set = 1'b1;
                end else if (inc_edge) begin
                    to_d = '0;
                    if (state_q == SET_HORA) ajh_d = 1'b1;
                    else                     ajm_d = 1'b1;
                end else if (tick) begin
                    if (to_q == TO_LAST) exit_set = 1'b1;
                    else                 to_d = to_q + TW'(1);
                end
                // Re-phase the prescaler so the first second after a set is a full one.
                if (exit_set) begin
                    state_d = RUN;
                    zera_d  = 1'b1;
                    presc_d = '0;
                    to_d    = '0;
                end
            end
            default: state_d = RUN;
        endcase

        enable_d = (state_d == RUN);
        pisca_d  = (state_d == RUN) || (presc_d < PRESC_HALF);
    end

    always_ff @(posedge maqc_clock or negedge maqc_reset) begin
        if (!maqc_reset) begin
            state_q    <= RUN;
            presc_q    <= '0;
            to_q       <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            enable_q   <= 1'b0;
            tick_q     <= 1'b0;
            ajh_q      <= 1'b0;
            ajm_q      <= 1'b0;
            zera_q     <= 1'b0;
            pisca_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            to_q       <= to_d;
            btn_s1_q   <= {maqc_btn_inc, maqc_btn_modo};
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            enable_q   <= enable_d;
            tick_q     <= tick_d;
            ajh_q      <= ajh_d;
            ajm_q      <= ajm_d;
            zera_q     <= zera_d;
            pisca_q    <= pisca_d;
        end
    end

    assign maqc_enable      = enable_q;
    assign maqc_tick_seg    = tick_q;
    assign maqc_ajuste_hora = ajh_q;
    assign maqc_ajuste_min  = ajm_q;
    assign maqc_zera_seg    = zera_q;
    assign maqc_modo        = state_q;
    assign maqc_pisca       = pisca_q;

endmodule

// File: tb/tb_maq_controle.sv
// tb_maq_controle -- directed bench for maq_controle with DIV=10, TIMEOUT_S=3.
// k counts rising edges since the latest reset release; outputs are sampled
// 1 ns after each edge. Expected values are written out by hand per edge.
module tb_maq_controle;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_modo = 1'b0;
    logic       btn_inc = 1'b0;
    logic       enable, tick_seg, aj_hora, aj_min, zera_seg, pisca;
    logic [1:0] modo;

    int k = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       m;
        logic       i;
        logic [1:0] modo;
        logic       en;
        logic       tick;
        logic       ah;
        logic       am;
        logic       zera;
        logic       pisca;
    } vec_t;

    vec_t tbl[$];

    maq_controle #(.DIV(10), .TIMEOUT_S(3)) dut (
        .maqc_clock      (clk),
        .maqc_reset      (rst_n),
        .maqc_btn_modo   (btn_modo),
        .maqc_btn_inc    (btn_inc),
        .maqc_enable     (enable),
        .maqc_tick_seg   (tick_seg),
        .maqc_ajuste_hora(aj_hora),
        .maqc_ajuste_min (aj_min),
        .maqc_zera_seg   (zera_seg),
        .maqc_modo       (modo),
        .maqc_pisca      (pisca)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic add(input logic m, input logic i, input logic [1:0] md,
                       input logic en, input logic tk, input logic ah,
                       input logic am, input logic z, input logic p);
        vec_t v;
        v.m = m; v.i = i; v.modo = md; v.en = en; v.tick = tk;
        v.ah = ah; v.am = am; v.zera = z; v.pisca = p;
        tbl.push_back(v);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_modo"},   modo, 0);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_tick"},   tick_seg, 0);
        chk({tag, "_ajh"},    aj_hora, 0);
        chk({tag, "_ajm"},    aj_min, 0);
        chk({tag, "_zera"},   zera_seg, 0);
        chk({tag, "_pisca"},  pisca, 0);
    endtask

    task automatic run_idle(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            step();
            chk({tag, "_modo"},  modo, 0);
            chk({tag, "_en"},    enable, 1);
            chk({tag, "_tick"},  tick_seg, (k % 10 == 0) ? 1 : 0);
            chk({tag, "_ajh"},   aj_hora, 0);
            chk({tag, "_ajm"},   aj_min, 0);
            chk({tag, "_zera"},  zera_seg, 0);
            chk({tag, "_pisca"}, pisca, 1);
        end
    endtask

    initial begin
        // Table covers edges k=26..56: enter SET_HORA with a held modo,
        // adjust hour, go to SET_MIN, adjust minute, return to RUN.
        add(1,0,0,1,0,0,0,0,1); // k26
        add(1,0,0,1,0,0,0,0,1); // k27
        add(1,0,1,0,0,0,0,0,0); // k28 enter SET_HORA
        add(1,0,1,0,0,0,0,0,0); // k29
        add(1,0,1,0,0,0,0,0,1); // k30
        add(0,0,1,0,0,0,0,0,1); // k31
        add(0,1,1,0,0,0,0,0,1); // k32 inc sampled
        add(0,0,1,0,0,0,0,0,1); // k33
        add(0,0,1,0,0,1,0,0,1); // k34 ajuste_hora
        add(0,0,1,0,0,0,0,0,0); // k35
        add(1,0,1,0,0,0,0,0,0); // k36 modo sampled
        add(0,0,1,0,0,0,0,0,0); // k37
        add(0,0,2,0,0,0,0,0,0); // k38 enter SET_MIN
        add(0,1,2,0,0,0,0,0,0); // k39 inc sampled
        add(0,0,2,0,0,0,0,0,1); // k40
        add(0,0,2,0,0,0,1,0,1); // k41 ajuste_min
        add(0,0,2,0,0,0,0,0,1); // k42
        add(1,0,2,0,0,0,0,0,1); // k43 modo sampled
        add(0,0,2,0,0,0,0,0,1); // k44
        add(0,0,0,1,0,0,0,1,1); // k45 back to RUN, zera_seg
        for (int kk = 46; kk <= 56; kk++)
            add(0, 0, 2'd0, 1'b1, (kk == 55), 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;

        // Idle run: enable from first edge, tick every 10 edges
        run_idle("run", 25);

        // Table-driven sequence
        for (int r = 0; r < tbl.size(); r++) begin
            btn_modo = tbl[r].m;
            btn_inc  = tbl[r].i;
            step();
            chk($sformatf("tbl%0d_modo", r),  modo,     tbl[r].modo);
            chk($sformatf("tbl%0d_en", r),    enable,   tbl[r].en);
            chk($sformatf("tbl%0d_tick", r),  tick_seg, tbl[r].tick);
            chk($sformatf("tbl%0d_ajh", r),   aj_hora,  tbl[r].ah);
            chk($sformatf("tbl%0d_ajm", r),   aj_min,   tbl[r].am);
            chk($sformatf("tbl%0d_zera", r),  zera_seg, tbl[r].zera);
            chk($sformatf("tbl%0d_pisca", r), pisca,    tbl[r].pisca);
        end
        btn_modo = 1'b0;
        btn_inc  = 1'b0;

        // Timeout: SET_HORA entered at k59, ticks at 65/75/85, return at 85
        for (int kk = 57; kk <= 86; kk++) begin
            btn_modo = (kk == 57);
            step();
            btn_modo = 1'b0;
            chk("to_modo", modo, (kk >= 59 && kk < 85) ? 1 : 0);
            chk("to_zera", zera_seg, (kk == 85) ? 1 : 0);
            chk("to_tick", tick_seg, 0);
            chk("to_ajh",  aj_hora, 0);
        end

        // Timeout restart: inc edge lands on tick 2 (k105), return at k135
        for (int kk = 87; kk <= 136; kk++) begin
            btn_modo = (kk == 87);
            btn_inc  = (kk == 103);
            step();
            btn_modo = 1'b0;
            btn_inc  = 1'b0;
            chk("tr_modo", modo, (kk >= 89 && kk < 135) ? 1 : 0);
            chk("tr_ajh",  aj_hora, (kk == 105) ? 1 : 0);
            chk("tr_zera", zera_seg, (kk == 135) ? 1 : 0);
            chk("tr_tick", tick_seg, 0);
            chk("tr_en",   enable, (kk >= 89 && kk < 135) ? 0 : 1);
        end

        // Simultaneous modo+inc in SET_HORA, then SET_MIN blink; an inc
        // is launched at k157 and still in the sync pipeline at k158
        for (int kk = 137; kk <= 158; kk++) begin
            btn_modo = (kk == 137 || kk == 141);
            btn_inc  = (kk == 141 || kk == 157);
            step();
            btn_modo = 1'b0;
            btn_inc  = 1'b0;
            chk("sim_modo", modo, (kk < 139) ? 0 : (kk < 143) ? 1 : 2);
            chk("sim_ajh",  aj_hora, 0);
            chk("sim_ajm",  aj_min, 0);
            chk("sim_tick", tick_seg, 0);
            if (kk >= 143)
                chk("sim_pisca", pisca, (((kk - 135) % 10) < 5) ? 1 : 0);
        end

        // Reset mid-pipeline in SET_MIN
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("arst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        run_idle("post", 21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maq_controle.md
Name: maq_controle

Overview:
- Mode/sequencing controller for the digital clock's counter chain (seconds, minutes, hours machines).
- Generates the 1 Hz count tick in run mode and runs the time-set user interface: mode button cycles run -> set hours -> set minutes -> run.
- Issues single-cycle adjust pulses to the hour and minute machines, and a blink flag for the display.
- Sits between the board buttons/clock and the counter machines.

Parameters:
- DIV, 50000000, clock cycles per 1 s tick (>=4, even).
- TIMEOUT_S, 10, seconds without a button edge in a set mode before automatic return to run (>=1).

Ports:
- maqc_clock  input  1  system clock, rising edge.
- maqc_reset  input  1  asynchronous, active-low reset.
- maqc_btn_modo  input  1  raw mode button, active-high, asynchronous to clock.
- maqc_btn_inc  input  1  raw increment button, active-high, asynchronous to clock.
- maqc_enable  output  1  1 in RUN; count enable for the seconds chain.
- maqc_tick_seg  output  1  one-cycle 1 Hz increment pulse, RUN only.
- maqc_ajuste_hora  output  1  one-cycle hour adjust pulse.
- maqc_ajuste_min  output  1  one-cycle minute adjust pulse.
- maqc_zera_seg  output  1  one-cycle pulse: clear seconds on exit from a set mode.
- maqc_modo  output  2  00 RUN, 01 SET_HORA, 10 SET_MIN (11 never driven).
- maqc_pisca  output  1  1 = show the field being set; 0 = blank it.

Behaviour:
- Reset (maqc_reset=0, asynchronous):
  - State goes to RUN.
  - Prescaler, timeout counter, sync and edge flops all go to 0.
  - All pulse outputs = 0, maqc_enable = 0, maqc_modo = 00, maqc_pisca = 0.
  - maqc_enable rises on the first clock edge after reset deasserts.
- Button path:
  - Each button passes through 2 sync flops, then a previous-value flop.
  - Edge = sync2 & ~prev.
  - Input first sampled high at edge N: the edge is detected in the cycle after N+1 and acts on edge N+2.
  - Registered pulses are visible from N+2 for exactly 1 cycle.
  - A held button gives one edge only; there is no auto-repeat.
- Prescaler: counts 0..DIV-1 and wraps. The internal tick is high when count == DIV-1.
- FSM, all outputs registered:
  - RUN:
    - maqc_enable = 1; maqc_tick_seg = internal tick.
    - modo edge -> SET_HORA; inc edge ignored.
  - SET_HORA:
    - maqc_enable = 0; no tick_seg.
    - inc edge -> maqc_ajuste_hora pulse.
    - modo edge -> SET_MIN.
  - SET_MIN:
    - inc edge -> maqc_ajuste_min pulse.
    - modo edge -> RUN.
- Timeout:
  - In SET_HORA or SET_MIN, the timeout counter increments on each internal tick.
  - Any button edge clears it to 0.
  - Counter reaching TIMEOUT_S -> RUN on the same edge it would reach the value.
  - Entering a set mode clears it.
- Exit to RUN (via modo or timeout):
  - maqc_zera_seg pulses 1 cycle.
  - Prescaler is reset to 0 on the same edge, so the first tick_seg comes DIV cycles after re-entry.
- Pisca:
  - RUN: 1.
  - Set modes: 1 while prescaler < DIV/2, else 0 (50% blink at 1 Hz, registered).
- Simultaneous events:
  - modo and inc edges in the same cycle: modo wins; no adjust pulse.
  - Button edge and timeout expiry in the same cycle: button wins. The timeout is cleared and the modo edge is processed normally.
- Mode changes do not generate adjust pulses.
- At most one of tick_seg, ajuste_hora, ajuste_min is high in any cycle.
- Reset asserted mid-operation: immediate return to RUN.
  - Any pulse in flight is dropped.
  - No zera_seg is issued.

Test Plan (DIV=10, TIMEOUT_S=3):
- Reset release, no buttons -> maqc_modo=00, enable=1, tick_seg high 1 cycle every 10 cycles; ajuste_*=0, zera_seg=0.
- modo pulse held 5 cycles -> exactly one transition to modo=01, 3rd edge after first sampling. Then inc pulse -> exactly one ajuste_hora cycle, ajuste_min=0, tick_seg stays 0.
- modo, inc, modo sequence -> modo 01->10, one ajuste_min pulse. Final modo -> modo=00, zera_seg one cycle, first tick_seg exactly 10 cycles later.
- Enter SET_HORA, no buttons -> auto-return to RUN after 3 internal ticks (~30 cycles) with zera_seg. An inc edge at tick 2 restarts the count (return at ~5 ticks).
- modo and inc raw inputs rise the same cycle in SET_HORA -> modo=10, no ajuste_hora. In SET_MIN, pisca toggles 5 high / 5 low.
- Assert reset during SET_MIN, mid-way through an inc edge's sync pipeline -> outputs at reset values immediately, no pulse after release, modo=00.
